// File: rtl/clk_diag_sequencer_pkg.sv
// Shared CLK diagnostic definitions: ds select code, function codes and sequencer states.
package clk_diag_sequencer_pkg;

  localparam logic [3:0] CLK_DS_SEL     = 4'b0000;
  localparam logic [2:0] FUNC_START     = 3'o1;
  localparam logic [2:0] FUNC_CLR_RESET = 3'o6;
  localparam logic [2:0] FUNC_SET_RESET = 3'o7;

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_STROBE, ST_SETTLE, ST_NEXT} tClkDiagState;
  typedef enum logic {MODE_SEQ, MODE_ONE} tClkDiagMode;

  function automatic logic [6:0] clk_diag_ds(input logic [2:0] func);
    return {CLK_DS_SEL, func};
  endfunction

endpackage

// File: rtl/clk_diag_sequencer_if.sv
// Request/handshake and EBUS diag signals between the boot logic and the CLK sequencer.
interface clk_diag_sequencer_if;
  logic       mrStart;
  logic       fnReq;
  logic [2:0] fnCode;
  logic       abort;
  logic [6:0] ds;
  logic       diagStrobe;
  logic       fnAck;
  logic       busy;
  logic       done;
  logic       aborted;

  modport master (
    output mrStart, fnReq, fnCode, abort,
    input  ds, diagStrobe, fnAck, busy, done, aborted
  );

  modport slave (
    input  mrStart, fnReq, fnCode, abort,
    output ds, diagStrobe, fnAck, busy, done, aborted
  );
endinterface

// File: rtl/ebus_clk_edge.sv
// EBUS_CLK edge detector shared by EBUS agents; flags are valid the clk after a transition.
module ebus_clk_edge (
  input  logic clk,
  input  logic FPGA_RESET_N,
  input  logic EBUS_CLK,
  output logic neg,
  output logic pos
);
  logic r_ebPrev;

  always_ff @(posedge clk or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) r_ebPrev <= 1'b0;
    else               r_ebPrev <= EBUS_CLK;
  end

  assign neg = r_ebPrev & ~EBUS_CLK;
  assign pos = ~r_ebPrev & EBUS_CLK;
endmodule

// File: rtl/clk_diag_sequencer.sv
// Issues CLK diagnostic functions on the EBUS diag interface, either a whole master-reset
// sequence or single requested functions, with strobes aligned to EBUS_CLK falling edges.
module clk_diag_sequencer
  import clk_diag_sequencer_pkg::*;
#(
  parameter int                  NSTEPS = 3,
  parameter logic [NSTEPS*3-1:0] SEQ    = {FUNC_SET_RESET, FUNC_START, FUNC_CLR_RESET},
  parameter int                  SETTLE = 4
) (
  input  logic               clk,
  input  logic               FPGA_RESET_N,
  input  logic               EBUS_CLK,
  clk_diag_sequencer_if.slave diag
);
  localparam int SW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int CW = $clog2(SETTLE + 1);

  // SEQ[0] occupies the most significant 3 bits of the packed parameter.
  function automatic logic [2:0] seq_at(input logic [SW-1:0] idx);
    return SEQ[(NSTEPS - 1 - int'(idx)) * 3 +: 3];
  endfunction

  logic w_neg, w_pos;

  ebus_clk_edge u_edge (
    .clk          (clk),
    .FPGA_RESET_N (FPGA_RESET_N),
    .EBUS_CLK     (EBUS_CLK),
    .neg          (w_neg),
    .pos          (w_pos)
  );

  tClkDiagState r_state, w_state;
  tClkDiagMode  r_mode,  w_mode;
  logic [SW-1:0] r_step, w_step;
  logic [2:0]    r_func, w_func;
  logic [CW-1:0] r_cnt,  w_cnt;
  logic [6:0]    r_ds,   w_ds;
  logic r_abt, w_abt, r_strobe, w_strobe, r_ack, w_ack;
  logic r_busy, w_busy, r_done, w_done, r_aborted, w_aborted;

  always_ff @(posedge clk or negedge FPGA_RESET_N) begin
    if (!FPGA_RESET_N) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_SEQ;
      r_step    <= '0;
      r_func    <= '0;
      r_cnt     <= '0;
      r_ds      <= '0;
      r_abt     <= 1'b0;
      r_strobe  <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_mode    <= w_mode;
      r_step    <= w_step;
      r_func    <= w_func;
      r_cnt     <= w_cnt;
      r_ds      <= w_ds;
      r_abt     <= w_abt;
      r_strobe  <= w_strobe;
      r_ack     <= w_ack;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_aborted <= w_aborted;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_mode    = r_mode;
    w_step    = r_step;
    w_func    = r_func;
    w_cnt     = r_cnt;
    w_ds      = r_ds;
    w_strobe  = r_strobe;
    w_abt     = r_abt | (diag.abort & (r_state != ST_IDLE));
    w_ack     = 1'b0;
    w_done    = 1'b0;
    w_aborted = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_abt = 1'b0;
        if (diag.mrStart) begin
          w_mode  = MODE_SEQ;
          w_step  = '0;
          w_func  = seq_at('0);
          w_state = ST_ARM;
        end else if (diag.fnReq) begin
          w_mode  = MODE_ONE;
          w_func  = diag.fnCode;
          w_ack   = 1'b1;
          w_state = ST_ARM;
        end
      end
      ST_ARM: begin
        if (w_neg) begin
          w_ds     = clk_diag_ds(r_func);
          w_strobe = 1'b1;
          w_state  = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (w_neg) begin
          w_ds     = '0;
          w_strobe = 1'b0;
          w_cnt    = '0;
          w_state  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == CW'(SETTLE)) w_state = ST_NEXT;
        else if (w_pos)           w_cnt   = r_cnt + 1'b1;
      end
      ST_NEXT: begin
        if (w_abt) begin
          w_aborted = 1'b1;
          w_abt     = 1'b0;
          w_state   = ST_IDLE;
        end else if (r_mode == MODE_ONE || r_step == SW'(NSTEPS - 1)) begin
          w_done  = 1'b1;
          w_abt   = 1'b0;
          w_state = ST_IDLE;
        end else begin
          w_step  = r_step + 1'b1;
          w_func  = seq_at(r_step + 1'b1);
          w_state = ST_ARM;
        end
      end
      default: w_state = ST_IDLE;
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  assign diag.ds         = r_ds;
  assign diag.diagStrobe = r_strobe;
  assign diag.fnAck      = r_ack;
  assign diag.busy       = r_busy;
  assign diag.done       = r_done;
  assign diag.aborted    = r_aborted;
endmodule
